mux_sample_shifter: RTL and testbench



---
 rtl/mux_sample_shifter.sv | 156 +++++++++++++++
 tb/tb_mux_sample_shifter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mux_sample_shifter.sv
// Serial capture stage behind the switch-driven 2-to-1 mux: samples the mux output
// at a divided rate into a WIDTH-bit word and reports the word, its popcount and status.
module mux_sample_shifter #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       mux_in,
  input  logic                       start,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(WIDTH+1)-1:0] ones_count,
  output logic                       busy,
  output logic                       done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               mux_sync1_r;
  logic               mux_sync2_r;
  logic               start_sync1_r;
  logic               start_sync2_r;
  logic               start_sync3_r;
  logic               mux_s;
  logic               start_pulse_s;
  logic               start_capture_s;
  logic               tick_s;
  logic               last_tick_s;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [CNT_W-1:0]   acc_r;
  logic [WIDTH-1:0]   sr_r;
  logic [WIDTH-1:0]   data_out_r;
  logic [CNT_W-1:0]   ones_count_r;
  logic               busy_r;
  logic               done_r;

  // Synchronize the switch-derived inputs; the third start flop gives a one-cycle rising-edge pulse.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mux_sync1_r   <= 1'b0;
      mux_sync2_r   <= 1'b0;
      start_sync1_r <= 1'b0;
      start_sync2_r <= 1'b0;
      start_sync3_r <= 1'b0;
    end else begin
      mux_sync1_r   <= mux_in;
      mux_sync2_r   <= mux_sync1_r;
      start_sync1_r <= start;
      start_sync2_r <= start_sync1_r;
      start_sync3_r <= start_sync2_r;
    end
  end

  assign mux_s         = mux_sync2_r;
  assign start_pulse_s = start_sync2_r & ~start_sync3_r;
  assign tick_s        = (state_r == ST_SHIFT) && (div_cnt_r == DIV_LAST);
  assign last_tick_s   = tick_s && (bit_cnt_r == BIT_LAST);

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start pulses seen while shifting are deliberately dropped.
  always_comb begin
    state_nxt_s     = state_r;
    start_capture_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_pulse_s) begin
          state_nxt_s     = ST_SHIFT;
          start_capture_s = 1'b1;
        end else begin
          state_nxt_s     = state_r;
        end
      end
      ST_SHIFT: begin
        if (last_tick_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sample datapath: rate divider, shift register, popcount accumulator and the published result.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      div_cnt_r    <= {DIV_W{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      acc_r        <= {CNT_W{1'b0}};
      sr_r         <= {WIDTH{1'b0}};
      data_out_r   <= {WIDTH{1'b0}};
      ones_count_r <= {CNT_W{1'b0}};
    end else if (start_capture_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      acc_r     <= {CNT_W{1'b0}};
      sr_r      <= {WIDTH{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      acc_r     <= acc_r + {{(CNT_W-1){1'b0}}, mux_s};
      sr_r      <= {sr_r[WIDTH-2:0], mux_s};
      // The result is published only on the final sample so readers never see a partial word.
      if (last_tick_s) begin
        data_out_r   <= {sr_r[WIDTH-2:0], mux_s};
        ones_count_r <= acc_r + {{(CNT_W-1){1'b0}}, mux_s};
      end else begin
        data_out_r   <= data_out_r;
        ones_count_r <= ones_count_r;
      end
    end else if (state_r == ST_SHIFT) begin
      div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  // Status flags registered from the next state so they track state_r exactly.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_SHIFT);
      done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign data_out   = data_out_r;
  assign ones_count = ones_count_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_mux_sample_shifter.sv
// Directed self-checking bench for mux_sample_shifter (WIDTH=8, DIV=4).
module tb_mux_sample_shifter;

  logic       clk;
  logic       rst_n;
  logic       mux_in;
  logic       start;
  logic [7:0] data_out;
  logic [3:0] ones_count;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_err;

  mux_sample_shifter #(.WIDTH(8), .DIV(4)) dut (
    .Clock      (clk),
    .Resetn     (rst_n),
    .mux_in     (mux_in),
    .start      (start),
    .data_out   (data_out),
    .ones_count (ones_count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full capture from a start pulse, shifting pat MSB-first, one bit per tick window.
  task automatic capture(input string tag, input logic [7:0] pat, input logic [7:0] prev_data,
                         input logic [3:0] prev_cnt, input logic [3:0] exp_cnt, input bit toggle_start);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check({tag, ".busy_pre"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, ".busy_entry"}, {31'd0, busy}, 32'd1);
    check({tag, ".done_entry"}, {31'd0, done}, 32'd0);
    mux_in = pat[7];
    for (int k = 1; k < 8; k++) begin
      repeat (4) @(negedge clk);
      check({tag, ".busy_mid"}, {31'd0, busy}, 32'd1);
      check({tag, ".data_hold"}, {24'd0, data_out}, {24'd0, prev_data});
      check({tag, ".cnt_hold"}, {28'd0, ones_count}, {28'd0, prev_cnt});
      mux_in = pat[7-k];
      if (toggle_start && k == 3) start = 1'b1;
      if (toggle_start && k == 4) start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check({tag, ".done_early"}, {31'd0, done}, 32'd0);
    check({tag, ".data_late"}, {24'd0, data_out}, {24'd0, prev_data});
    @(negedge clk);
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, ".data"}, {24'd0, data_out}, {24'd0, pat});
    check({tag, ".ones"}, {28'd0, ones_count}, {28'd0, exp_cnt});
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    mux_in = 1'b0;
    start  = 1'b0;

    // 1: reset with random inputs
    repeat (3) begin
      @(negedge clk);
      mux_in = 1'($urandom_range(1, 0));
      start  = 1'($urandom_range(1, 0));
    end
    check("rst.data", {24'd0, data_out}, 32'd0);
    check("rst.ones", {28'd0, ones_count}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    start  = 1'b0;
    mux_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle.busy", {31'd0, busy}, 32'd0);
    check("idle.done", {31'd0, done}, 32'd0);

    // 2: all ones
    capture("ones", 8'hFF, 8'h00, 4'd0, 4'd8, 1'b0);
    // 4: start toggled mid-capture is ignored
    capture("toggle", 8'h5C, 8'hFF, 4'd8, 4'd4, 1'b1);
    // 3: pattern 1,0,1,1,0,0,1,0
    capture("pat", 8'hB2, 8'h5C, 4'd4, 4'd4, 1'b0);
    // 6: restart from DONE holding 0xB2 with mux_in low
    capture("redo", 8'h00, 8'hB2, 4'd4, 4'd0, 1'b0);
    capture("pre_rst", 8'h81, 8'h00, 4'd0, 4'd2, 1'b0);

    // 5: async reset mid-cycle after the 5th tick
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    mux_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mid.busy", {31'd0, busy}, 32'd1);
    check("mid.data", {24'd0, data_out}, 32'h81);
    #2 rst_n = 1'b0;
    #1;
    check("arst.data", {24'd0, data_out}, 32'd0);
    check("arst.ones", {28'd0, ones_count}, 32'd0);
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    mux_in = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst.busy", {31'd0, busy}, 32'd0);
    capture("after_rst", 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
